// File: rtl/host_mbx_pkg.sv
// Shared types and constants for the host mailbox sequencer: FSM states,
// host flag/status codes and a width-generic byte-order swap.
package host_mbx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_RUN,
        S_RD_WAIT,
        S_FINISH,
        S_ERR
    } mbx_state_t;

    localparam logic [31:0] CMD_START = 32'h0001_0000;
    localparam logic [31:0] ST_BUSY   = 32'd2;
    localparam logic [31:0] ST_DONE   = 32'd4;
    localparam logic [31:0] ST_ERR    = 32'd8;

    // Widest data bus the swap helper supports; callers cast in and out.
    localparam int BSWAP_MAX_W = 256;

    function automatic logic [BSWAP_MAX_W-1:0] byteswap(input logic [BSWAP_MAX_W-1:0] d,
                                                        input int nbytes);
        logic [BSWAP_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BSWAP_MAX_W / 8; i++) begin
            if (i < nbytes) begin
                r[i*8 +: 8] = d[(nbytes-1-i)*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mbx_watchdog.sv
// Read-wait watchdog: counts cycles while enabled and flags expiry when the
// count reaches TIMEOUT-1. Used only when HOST_MBX_WATCHDOG_EN is defined.
module mbx_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = en && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/host_mailbox_sequencer.sv
// Host handshake and memory sequencer between shared SRAM and the compute core.
// Optional read-wait watchdog and ERROR status enabled by HOST_MBX_WATCHDOG_EN.
module host_mailbox_sequencer
    import host_mbx_pkg::*;
#(
    parameter int               ADDR_W       = 21,
    parameter int               DATA_W       = 32,
    parameter int               NUM_FRAMES   = 2,
    parameter int               SET_W        = 8,
    parameter int               RESULT_WORDS = 4,
    parameter logic [ADDR_W-1:0] RESULT_BASE = 21'h03CF96,
    parameter logic [ADDR_W-1:0] FLAG_ADDR   = '0,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 21'h07FFFE,
    parameter int               TIMEOUT      = 1024,
    localparam int              FRAME_W      = $clog2(NUM_FRAMES),
    localparam int              IDX_W        = $clog2(RESULT_WORDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in_flag,
    output logic               flag_we,
    output logic [ADDR_W-1:0]  flag_addr,
    output logic [DATA_W-1:0]  flag_wdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_rvalid,
    output logic               core_ready,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [ADDR_W-1:0]  core_addr,
    input  logic [SET_W-1:0]   core_set,
    input  logic [IDX_W-1:0]   core_wr_idx,
    input  logic [DATA_W-1:0]  core_wdata,
    output logic [DATA_W-1:0]  core_rdata,
    output logic               core_rvalid,
    input  logic               core_set_done,
    output logic [FRAME_W-1:0] frame_sel,
    output logic               error
);

    mbx_state_t         state_q, state_d;
    logic               armed_q, armed_d;
    logic               done_pend_q, done_pend_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               start_accept;
    logic               wd_expire;
    logic [ADDR_W-1:0]  result_addr;

    // RESULT_WORDS is a power of two, so the set offset is a shift.
    assign result_addr = RESULT_BASE + (ADDR_W'(core_set) << IDX_W) + ADDR_W'(core_wr_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            done_pend_q <= 1'b0;
            frame_q     <= FRAME_W'(NUM_FRAMES - 1);
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            done_pend_q <= done_pend_d;
            frame_q     <= frame_d;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        done_pend_d  = done_pend_q;
        frame_d      = frame_q;
        start_accept = 1'b0;
        flag_we      = 1'b0;
        flag_addr    = '0;
        flag_wdata   = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        core_ready   = 1'b0;
        core_rdata   = '0;
        core_rvalid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_flag == DATA_W'(CMD_START)) begin
                    if (armed_q) begin
                        start_accept = 1'b1;
                        armed_d      = 1'b0;
                        frame_d      = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0
                                                                             : frame_q + 1'b1;
                        state_d      = S_ACK;
                    end
                end else begin
                    armed_d = 1'b1;
                end
            end
            S_ACK: begin
                flag_we    = 1'b1;
                flag_addr  = FLAG_ADDR;
                flag_wdata = DATA_W'(ST_BUSY);
                state_d    = S_RUN;
            end
            S_RUN: begin
                core_ready = 1'b1;
                if (core_req && core_we) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = result_addr;
                    mem_wdata = DATA_W'(byteswap(BSWAP_MAX_W'(core_wdata), DATA_W / 8));
                    if (core_set_done) state_d = S_FINISH;
                end else if (core_req) begin
                    mem_req     = 1'b1;
                    mem_addr    = core_addr;
                    done_pend_d = core_set_done;
                    state_d     = S_RD_WAIT;
                end else if (core_set_done) begin
                    state_d = S_FINISH;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    core_rvalid = 1'b1;
                    core_rdata  = DATA_W'(byteswap(BSWAP_MAX_W'(mem_rdata), DATA_W / 8));
                    done_pend_d = 1'b0;
                    state_d     = done_pend_q ? S_FINISH : S_RUN;
                end else if (wd_expire) begin
                    done_pend_d = 1'b0;
                    state_d     = S_ERR;
                end
            end
            S_FINISH: begin
                flag_we    = 1'b1;
                flag_addr  = STATUS_ADDR;
                flag_wdata = DATA_W'(ST_DONE);
                state_d    = S_IDLE;
            end
            S_ERR: begin
`ifdef HOST_MBX_WATCHDOG_EN
                flag_we    = 1'b1;
                flag_addr  = STATUS_ADDR;
                flag_wdata = DATA_W'(ST_ERR);
`endif
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_sel = frame_q;

`ifdef HOST_MBX_WATCHDOG_EN
    logic wd_clr;
    logic wd_en;
    logic error_q;

    // Clearing on the issuing RUN cycle makes the first RD_WAIT cycle count 0.
    assign wd_clr = (state_q == S_RUN) && core_req && !core_we;
    assign wd_en  = (state_q == S_RD_WAIT);

    mbx_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else if (start_accept) begin
            error_q <= 1'b0;
        end else if (state_q == S_ERR) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign wd_expire = 1'b0;
    assign error     = 1'b0;
`endif

endmodule
